// File: rtl/oven_pkg.sv
// rtl/oven_pkg.sv - shared types, step codes and default timing for the oven key conditioner
package oven_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WINDOW,
        HOLD,
        REPEAT,
        RELEASE_WAIT
    } oven_state_t;

    localparam logic [2:0] STEP_NONE = 3'd0;
    localparam logic [2:0] STEP_1    = 3'd1;
    localparam logic [2:0] STEP_2    = 3'd2;
    localparam logic [2:0] STEP_3    = 3'd3;
    localparam logic [2:0] STEP_4    = 3'd4;
    localparam logic [2:0] STEP_5    = 3'd5;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_CHORD_CYCLES    = 2500000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_RATE     = 5000000;

    // Only a single raised step switch with sw5 low selects a step.
    function automatic logic [2:0] step_decode(input logic [5:0] sw);
        logic [2:0] code;
        code = STEP_NONE;
        if (!sw[5]) begin
            case (sw[4:0])
                5'b00001: code = STEP_1;
                5'b00010: code = STEP_2;
                5'b00100: code = STEP_3;
                5'b01000: code = STEP_4;
                5'b10000: code = STEP_5;
                default:  code = STEP_NONE;
            endcase
        end
        return code;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two-flop synchroniser plus stable-level debounce for one active-low key
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic held
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             pressed;
    logic [CNT_W-1:0] cnt;

    assign pressed = ~sync2;

    // Synchronisers reset to the released level so a key held through reset debounces afresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            cnt   <= '0;
            held  <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            if (pressed == held) begin
                cnt <= '0;
            end else if (cnt >= CNT_LAST) begin
                held <= pressed;
                cnt  <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/oven_key_conditioner.sv
// rtl/oven_key_conditioner.sv - key debounce, chord/auto-repeat FSM and step switch decode
module oven_key_conditioner
    import oven_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CHORD_CYCLES    = DEF_CHORD_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key0,
    input  logic       key1,
    input  logic [5:0] sw,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       confirm_pulse,
    output logic [2:0] step_sel,
    output logic       key0_held,
    output logic       key1_held
);

    localparam int MAX_PARAM = max_int(max_int(DEBOUNCE_CYCLES, CHORD_CYCLES),
                                       max_int(REPEAT_DELAY, REPEAT_RATE));
    localparam int CNT_W     = $clog2(MAX_PARAM + 1);

    localparam logic [CNT_W-1:0] CHORD_LAST  = CNT_W'(CHORD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST   = CNT_W'(REPEAT_RATE - 1);

    oven_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             first_q, first_d;
    logic             first_pressed, other_pressed;
    logic             step_req, chord_req;
    logic             pulse_busy;
    logic             inc_d, dec_d, confirm_d;
    logic [5:0]       sw_s1, sw_s2;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_key0_debounce (
        .clk  (clk),
        .rst  (rst),
        .key_n(key0),
        .held (key0_held)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_key1_debounce (
        .clk  (clk),
        .rst  (rst),
        .key_n(key1),
        .held (key1_held)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_s1    <= '0;
            sw_s2    <= '0;
            step_sel <= STEP_NONE;
        end else begin
            sw_s1    <= sw;
            sw_s2    <= sw_s1;
            step_sel <= step_decode(sw_s2);
        end
    end

    // first_q remembers which key opened the window: 0 = key0 (inc), 1 = key1 (dec).
    assign first_pressed = first_q ? key1_held : key0_held;
    assign other_pressed = first_q ? key0_held : key1_held;
    assign cnt_inc       = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign pulse_busy    = inc_pulse | dec_pulse | confirm_pulse;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        step_req  = 1'b0;
        chord_req = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (key0_held && key1_held) begin
                    chord_req = 1'b1;
                    state_d   = RELEASE_WAIT;
                end else if (key0_held || key1_held) begin
                    first_d = key1_held;
                    state_d = WINDOW;
                end
            end
            WINDOW: begin
                if (other_pressed) begin
                    chord_req = 1'b1;
                    state_d   = RELEASE_WAIT;
                end else if (!first_pressed) begin
                    step_req = 1'b1;
                    state_d  = IDLE;
                end else if (cnt_q >= CHORD_LAST) begin
                    step_req = 1'b1;
                    cnt_d    = '0;
                    state_d  = HOLD;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HOLD, REPEAT: begin
                if (other_pressed) begin
                    state_d = RELEASE_WAIT;
                end else if (!first_pressed) begin
                    state_d = IDLE;
                end else if (cnt_q >= ((state_q == HOLD) ? DELAY_LAST : RATE_LAST)) begin
                    step_req = 1'b1;
                    cnt_d    = '0;
                    state_d  = REPEAT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RELEASE_WAIT: begin
                cnt_d = '0;
                if (!key0_held && !key1_held) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A pulse already on the output masks a new one so requests can never abut.
    assign inc_d     = step_req & ~first_q & ~pulse_busy;
    assign dec_d     = step_req & first_q & ~pulse_busy;
    assign confirm_d = chord_req & ~pulse_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            first_q       <= 1'b0;
            inc_pulse     <= 1'b0;
            dec_pulse     <= 1'b0;
            confirm_pulse <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            first_q       <= first_d;
            inc_pulse     <= inc_d;
            dec_pulse     <= dec_d;
            confirm_pulse <= confirm_d;
        end
    end

endmodule

// File: tb/tb_oven_key_conditioner.sv
// tb/tb_oven_key_conditioner.sv - directed self-checking bench for oven_key_conditioner
module tb_oven_key_conditioner;

    localparam int DB    = 4;
    localparam int CHORD = 10;
    localparam int DELAY = 20;
    localparam int RATE  = 5;

    logic       clk;
    logic       rst;
    logic       key0;
    logic       key1;
    logic [5:0] sw;
    logic       inc_pulse;
    logic       dec_pulse;
    logic       confirm_pulse;
    logic [2:0] step_sel;
    logic       key0_held;
    logic       key1_held;

    int n_checks;
    int n_fails;
    int cyc;
    int inc_cnt;
    int dec_cnt;
    int conf_cnt;
    int k1_seen;
    int viol;
    int prev_any;
    int inc_times[$];

    oven_key_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .CHORD_CYCLES   (CHORD),
        .REPEAT_DELAY   (DELAY),
        .REPEAT_RATE    (RATE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key0         (key0),
        .key1         (key1),
        .sw           (sw),
        .inc_pulse    (inc_pulse),
        .dec_pulse    (dec_pulse),
        .confirm_pulse(confirm_pulse),
        .step_sel     (step_sel),
        .key0_held    (key0_held),
        .key1_held    (key1_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        inc_cnt  = 0;
        dec_cnt  = 0;
        conf_cnt = 0;
        k1_seen  = 0;
        viol     = 0;
        prev_any = 0;
    end

    always @(negedge clk) begin
        if (inc_pulse) begin
            inc_cnt = inc_cnt + 1;
            inc_times.push_back(cyc);
        end
        if (dec_pulse)     dec_cnt  = dec_cnt + 1;
        if (confirm_pulse) conf_cnt = conf_cnt + 1;
        if (key1_held)     k1_seen  = k1_seen + 1;
        if (32'(inc_pulse) + 32'(dec_pulse) + 32'(confirm_pulse) > 1) viol = viol + 1;
        if ((inc_pulse || dec_pulse || confirm_pulse) && prev_any != 0) viol = viol + 1;
        prev_any = (inc_pulse || dec_pulse || confirm_pulse) ? 1 : 0;
    end

    task automatic check_val(input string tag, input int actual, input int expected);
        n_checks = n_checks + 1;
        if (actual !== expected) begin
            n_fails = n_fails + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    int b_inc, b_dec, b_conf, b_k1, b_idx, t_rel, lat, ok, n_rep;

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst  = 1'b1;
        key0 = 1'b1;
        key1 = 1'b1;
        sw   = 6'b000000;
        idle_cycles(3);
        check_val("rst_inc",    32'(inc_pulse), 0);
        check_val("rst_dec",    32'(dec_pulse), 0);
        check_val("rst_conf",   32'(confirm_pulse), 0);
        check_val("rst_step",   32'(step_sel), 0);
        check_val("rst_k0held", 32'(key0_held), 0);
        check_val("rst_k1held", 32'(key1_held), 0);
        rst = 1'b0;
        idle_cycles(5);

        // Short single press of key0
        b_inc = inc_cnt; b_dec = dec_cnt; b_conf = conf_cnt;
        key0 = 1'b0;
        idle_cycles(6);
        key0 = 1'b1;
        idle_cycles(40);
        check_val("tap_inc",  inc_cnt - b_inc, 1);
        check_val("tap_dec",  dec_cnt - b_dec, 0);
        check_val("tap_conf", conf_cnt - b_conf, 0);

        // key1 low with 2-cycle high glitches: never 4 stable cycles
        b_inc = inc_cnt; b_dec = dec_cnt; b_conf = conf_cnt; b_k1 = k1_seen;
        for (int i = 0; i < 6; i++) begin
            key1 = 1'b0;
            idle_cycles(3);
            key1 = 1'b1;
            idle_cycles(2);
        end
        idle_cycles(30);
        check_val("glitch_inc",  inc_cnt - b_inc, 0);
        check_val("glitch_dec",  dec_cnt - b_dec, 0);
        check_val("glitch_conf", conf_cnt - b_conf, 0);
        check_val("glitch_held", k1_seen - b_k1, 0);

        // Chord: key1 joins 5 cycles after key0
        b_inc = inc_cnt; b_dec = dec_cnt; b_conf = conf_cnt;
        key0 = 1'b0;
        idle_cycles(5);
        key1 = 1'b0;
        idle_cycles(30);
        key0 = 1'b1;
        key1 = 1'b1;
        idle_cycles(30);
        check_val("chord_conf", conf_cnt - b_conf, 1);
        check_val("chord_inc",  inc_cnt - b_inc, 0);
        check_val("chord_dec",  dec_cnt - b_dec, 0);

        // Auto-repeat: key0 held 60 cycles
        b_idx = inc_times.size();
        t_rel = cyc;
        key0 = 1'b0;
        idle_cycles(60);
        key0 = 1'b1;
        idle_cycles(20);
        n_rep = inc_times.size() - b_idx;
        check_val("rep_count_range", (n_rep >= 6 && n_rep <= 8) ? 1 : 0, 1);
        if (n_rep >= 1) begin
            lat = inc_times[b_idx] - t_rel;
            check_val("rep_first_lat", (lat >= DB + CHORD && lat <= DB + CHORD + 4) ? 1 : 0, 1);
        end
        if (n_rep >= 2) check_val("rep_gap_delay", inc_times[b_idx+1] - inc_times[b_idx], DELAY);
        for (int i = 2; i < 6; i++) begin
            if (n_rep > i) check_val("rep_gap_rate", inc_times[b_idx+i] - inc_times[b_idx+i-1], RATE);
        end
        b_inc = inc_cnt;
        idle_cycles(30);
        check_val("rep_stop", inc_cnt - b_inc, 0);

        // Step switch decode
        sw = 6'b000100; idle_cycles(4); check_val("step_sw2",   32'(step_sel), 3);
        sw = 6'b100100; idle_cycles(4); check_val("step_sw5on", 32'(step_sel), 0);
        sw = 6'b000110; idle_cycles(4); check_val("step_two",   32'(step_sel), 0);
        sw = 6'b000001; idle_cycles(4); check_val("step_sw0",   32'(step_sel), 1);
        sw = 6'b010000; idle_cycles(4); check_val("step_sw4",   32'(step_sel), 5);
        sw = 6'b000000; idle_cycles(4); check_val("step_none",  32'(step_sel), 0);

        // Reset during REPEAT with key0 held
        key0 = 1'b0;
        idle_cycles(45);
        ok = 0;
        for (int i = 0; i < 20 && ok == 0; i++) begin
            if (inc_pulse) ok = 1;
            else idle_cycles(1);
        end
        check_val("rstrep_seen_pulse", ok, 1);
        rst = 1'b1;
        #1;
        check_val("rstrep_inc",    32'(inc_pulse), 0);
        check_val("rstrep_k0held", 32'(key0_held), 0);
        check_val("rstrep_conf",   32'(confirm_pulse), 0);
        idle_cycles(3);
        b_idx = inc_times.size();
        rst = 1'b0;
        t_rel = cyc;
        ok = 0;
        for (int i = 0; i < 60 && ok == 0; i++) begin
            idle_cycles(1);
            if (inc_times.size() > b_idx) ok = 1;
        end
        check_val("rstrep_repress", ok, 1);
        if (ok != 0) begin
            lat = inc_times[b_idx] - t_rel;
            check_val("rstrep_lat", (lat >= DB + CHORD) ? 1 : 0, 1);
        end
        key0 = 1'b1;
        idle_cycles(30);

        check_val("pulse_rules", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
